// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - shared FSM states, funct3 encodings and access-size helpers
package load_store_unit_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_RESP} lsu_state_e;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} lsu_size_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Unrecognised funct3 encodings fall back to a full-word access.
  function automatic lsu_size_e access_size(input logic [2:0] funct3, input logic is_store);
    lsu_size_e sz;
    sz = SZ_WORD;
    if (is_store) begin
      case (funct3)
        F3_SB:   sz = SZ_BYTE;
        F3_SH:   sz = SZ_HALF;
        F3_SW:   sz = SZ_WORD;
        default: sz = SZ_WORD;
      endcase
    end else begin
      case (funct3)
        F3_LB, F3_LBU: sz = SZ_BYTE;
        F3_LH, F3_LHU: sz = SZ_HALF;
        F3_LW:         sz = SZ_WORD;
        default:       sz = SZ_WORD;
      endcase
    end
    return sz;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] funct3, input logic is_store,
                                         input logic [1:0] offset);
    lsu_size_e sz;
    sz = access_size(funct3, is_store);
    return ((sz == SZ_HALF) && offset[0]) || ((sz == SZ_WORD) && (offset != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - store lane alignment / byte enables and load extraction with sign handling
module lsu_align
  import load_store_unit_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic [2:0]        funct3_i,
  input  logic              is_store_i,
  input  logic [1:0]        offset_i,
  input  logic [DWIDTH-1:0] wdata_i,
  input  logic [DWIDTH-1:0] rdata_i,
  output logic [3:0]        be_o,
  output logic [DWIDTH-1:0] wdata_o,
  output logic [DWIDTH-1:0] load_o
);

  lsu_size_e   size;
  logic        load_signed;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  always_comb begin
    size        = access_size(funct3_i, is_store_i);
    load_signed = !funct3_i[2];
    rd_byte     = rdata_i[{offset_i, 3'b000} +: 8];
    rd_half     = rdata_i[{offset_i[1], 4'b0000} +: 16];
    be_o        = 4'b1111;
    wdata_o     = wdata_i;
    load_o      = rdata_i;
    if (is_store_i) begin
      case (size)
        SZ_BYTE: begin
          be_o    = 4'b0001 << offset_i;
          wdata_o = {(DWIDTH/8){wdata_i[7:0]}};
        end
        SZ_HALF: begin
          be_o    = 4'b0011 << offset_i;
          wdata_o = {(DWIDTH/16){wdata_i[15:0]}};
        end
        default: ;
      endcase
    end
    case (size)
      SZ_BYTE: load_o = {{(DWIDTH-8){load_signed & rd_byte[7]}}, rd_byte};
      SZ_HALF: load_o = {{(DWIDTH-16){load_signed & rd_half[15]}}, rd_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - MEM-stage load/store unit: single outstanding access, pipeline stall, misalignment detect
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              is_load_i,
  input  logic              is_store_i,
  input  logic [2:0]        funct3_i,
  input  logic [AWIDTH-1:0] addr_i,
  input  logic [DWIDTH-1:0] wdata_i,
  input  logic [4:0]        rd_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [AWIDTH-1:0] mem_addr_o,
  output logic [3:0]        mem_be_o,
  output logic [DWIDTH-1:0] mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DWIDTH-1:0] mem_rdata_i,
  output logic              resp_valid_o,
  output logic [DWIDTH-1:0] resp_data_o,
  output logic [4:0]        resp_rd_o,
  output logic              stall_o,
  output logic              misaligned_o
);

  lsu_state_e        state_q, state_d;
  logic              is_store_q, is_store_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [DWIDTH-1:0] wdata_q, wdata_d;
  logic [DWIDTH-1:0] rdata_q, rdata_d;
  logic [4:0]        rd_q, rd_d;
  logic              misaligned_q, misaligned_d;

  logic              accept, access_misaligned, in_req, in_resp;
  logic [3:0]        be;
  logic [DWIDTH-1:0] wdata_aligned, load_data;

  always_comb begin
    state_d           = state_q;
    is_store_d        = is_store_q;
    funct3_d          = funct3_q;
    addr_d            = addr_q;
    wdata_d           = wdata_q;
    rdata_d           = rdata_q;
    rd_d              = rd_q;
    accept            = req_valid_i && (state_q == ST_IDLE) && (is_load_i || is_store_i);
    access_misaligned = is_misaligned(funct3_i, is_store_i, addr_i[1:0]);
    misaligned_d      = accept && access_misaligned;
    if (accept) begin
      is_store_d = is_store_i;
      funct3_d   = funct3_i;
      addr_d     = addr_i;
      wdata_d    = wdata_i;
      rd_d       = rd_i;
    end
    case (state_q)
      ST_IDLE: if (accept && !access_misaligned) state_d = ST_REQ;
      ST_REQ:  if (mem_gnt_i) state_d = is_store_q ? ST_IDLE : ST_WAIT;
      ST_WAIT: begin
        if (mem_rvalid_i) begin
          state_d = ST_RESP;
          rdata_d = mem_rdata_i;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      is_store_q   <= 1'b0;
      funct3_q     <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      rd_q         <= '0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      is_store_q   <= is_store_d;
      funct3_q     <= funct3_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      rd_q         <= rd_d;
      misaligned_q <= misaligned_d;
    end
  end

  lsu_align #(.DWIDTH(DWIDTH)) u_align (
    .funct3_i  (funct3_q),
    .is_store_i(is_store_q),
    .offset_i  (addr_q[1:0]),
    .wdata_i   (wdata_q),
    .rdata_i   (rdata_q),
    .be_o      (be),
    .wdata_o   (wdata_aligned),
    .load_o    (load_data)
  );

  // Bus and response fields are zeroed outside their valid phase so idle outputs stay quiet.
  assign in_req       = (state_q == ST_REQ);
  assign in_resp      = (state_q == ST_RESP);
  assign req_ready_o  = (state_q == ST_IDLE);
  assign mem_req_o    = in_req;
  assign mem_we_o     = in_req && is_store_q;
  assign mem_addr_o   = in_req ? {addr_q[AWIDTH-1:2], 2'b00} : '0;
  assign mem_be_o     = in_req ? be : '0;
  assign mem_wdata_o  = in_req ? wdata_aligned : '0;
  assign resp_valid_o = in_resp;
  assign resp_data_o  = in_resp ? load_data : '0;
  assign resp_rd_o    = in_resp ? rd_q : '0;
  assign stall_o      = (state_q != ST_IDLE) || (accept && !access_misaligned);
  assign misaligned_o = misaligned_q;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameters: AWIDTH, default 32, address width; DWIDTH, default 32, data width.
REQ-002 SHALL have ports (name  direction  width  meaning):
  clk  in  1  clock, rising edge
  reset  in  1  reset, asynchronous, active-high
  req_valid_i  in  1  MEM-stage request present
  req_ready_o  out  1  unit able to accept request
  is_load_i  in  1  request is a load
  is_store_i  in  1  request is a store
  funct3_i  in  3  RV32I load/store funct3
  addr_i  in  AWIDTH  effective byte address
  wdata_i  in  DWIDTH  store data, rs2 after bypass
  rd_i  in  5  load destination register
  mem_req_o  out  1  data-memory request
  mem_we_o  out  1  write request
  mem_addr_o  out  AWIDTH  word-aligned address
  mem_be_o  out  4  byte enables
  mem_wdata_o  out  DWIDTH  lane-aligned store data
  mem_gnt_i  in  1  memory accepted request
  mem_rvalid_i  in  1  read data valid
  mem_rdata_i  in  DWIDTH  read word
  resp_valid_o  out  1  load result valid, 1-cycle pulse
  resp_data_o  out  DWIDTH  extended load result
  resp_rd_o  out  5  load destination
  stall_o  out  1  freeze IF/ID/EX and EX/MEM
  misaligned_o  out  1  misaligned-access pulse

Function
REQ-003 SHALL implement FSM states IDLE, REQ, WAIT, RESP.
REQ-004 SHALL accept a request when req_valid_i, req_ready_o and (is_load_i or is_store_i) are all high; req_ready_o SHALL be 1 only in IDLE.
REQ-005 SHALL latch funct3, addr, aligned wdata, byte enables, rd and load/store type on acceptance.
REQ-006 SHALL treat LH/LHU/SH with addr[0]=1 and LW/SW with addr[1:0]!=0 as misaligned: pulse misaligned_o for one cycle after acceptance, issue no memory request, stay in IDLE.
REQ-007 IDLE->REQ on an aligned acceptance; in REQ, mem_req_o=1 until mem_gnt_i is sampled high.
REQ-008 REQ on grant: store -> IDLE; load -> WAIT.
REQ-009 WAIT -> RESP on mem_rvalid_i; mem_rvalid_i SHALL be ignored outside WAIT.
REQ-010 RESP: resp_valid_o=1 for exactly one cycle, then -> IDLE.
REQ-011 mem_addr_o = {addr[AWIDTH-1:2], 2'b00}; mem_we_o = 1 for stores only.
REQ-012 Byte enables: SB = 4'b0001<<addr[1:0]; SH = 4'b0011<<addr[1:0]; SW = 4'b1111; loads 4'b1111.
REQ-013 Store data: SB replicates byte to all 4 lanes; SH replicates halfword to both halves; SW unchanged.
REQ-014 Load extract: byte/half selected by addr[1:0]; LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
REQ-015 stall_o = (state != IDLE) or an aligned acceptance this cycle; de-asserted in the cycle after RESP or after a store grant.
REQ-016 Latency with grant in the issue cycle and rvalid one cycle later: load result 3 cycles after acceptance; store completes 1 cycle after acceptance.
REQ-017 Requests presented while not IDLE SHALL be ignored and never buffered.
REQ-018 funct3 values outside the RV32I load/store set SHALL be treated as word-size.

Reset
REQ-019 Reset SHALL force IDLE and set all outputs to 0, except req_ready_o=1.
REQ-020 Reset mid-operation SHALL abandon the access: mem_req_o falls immediately and any later rvalid is discarded.

Structure
REQ-021 The state enum and the load/store funct3 constants SHALL reside in the shared constants package.
REQ-022 Lane alignment and load extraction SHALL be one combinational sub-module, lsu_align.

Verification
REQ-023 LW addr 0x01000004, immediate gnt, rvalid next cycle, rdata 0xDEADBEEF -> resp_data 0xDEADBEEF 3 cycles after acceptance, stall_o high throughout.
REQ-024 LB addr 0x01000003, rdata 0x80123456 -> resp 0xFFFFFF80; LBU same -> 0x00000080.
REQ-025 SH addr 0x01000002, wdata 0x0000ABCD -> be 4'b1100, mem_wdata 0xABCDABCD, we=1.
REQ-026 LW addr 0x01000002 -> misaligned_o pulse, mem_req_o stays 0, stall_o low the following cycle.
REQ-027 SW with gnt delayed 3 cycles -> mem_req_o held 4 cycles, req_ready_o low until grant.
REQ-028 Reset asserted in WAIT, rvalid arriving 1 cycle later -> IDLE, resp_valid_o stays 0.
